pe_grid_feeder: RTL and testbench

Tagged multicast feeder that sits directly upstream of `PE_Grid_12x14` and drives its activation bus (`image_val_in`/`tag_col`/`valid_x`) and weight bus (`weight_val_in`/`tag_row`/`valid_y`). Buffers activation and weight packets arriving from the global buffer in two independent FIFOs, rejects out-of-range tags, and issues at most one activation and one weight per cycle. Issue is either independent per bus or paired, and the grid side can stall it.

---
 rtl/pe_grid_feeder.sv | 128 ++++++++++++
 tb/tb_pe_grid_feeder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_grid_feeder.sv
// Tagged multicast feeder for the PE grid: buffers activations and weights,
// filters out-of-range tags and issues one packet per bus per cycle.
module pe_grid_feeder #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 8,
    parameter int COLS   = 14,
    parameter int ROWS   = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          act_in_data,
    input  logic [TAG_W-1:0]           act_in_tag,
    input  logic                       act_in_valid,
    output logic                       act_in_ready,
    input  logic [DATA_W-1:0]          wgt_in_data,
    input  logic [TAG_W-1:0]           wgt_in_tag,
    input  logic                       wgt_in_valid,
    output logic                       wgt_in_ready,
    input  logic                       pair_mode,
    input  logic                       stall,
    output logic [DATA_W-1:0]          image_val_in,
    output logic [TAG_W-1:0]           tag_col,
    output logic                       valid_x,
    output logic [DATA_W-1:0]          weight_val_in,
    output logic [TAG_W-1:0]           tag_row,
    output logic                       valid_y,
    output logic [$clog2(DEPTH):0]     act_count,
    output logic [$clog2(DEPTH):0]     wgt_count,
    output logic                       tag_err,
    output logic [7:0]                 drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] COL_LIM = 32'(COLS);
    localparam logic [31:0] ROW_LIM = 32'(ROWS);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } pkt_t;

    pkt_t act_mem [DEPTH];
    pkt_t wgt_mem [DEPTH];

    logic [AW-1:0] act_wr, act_rd;
    logic [AW-1:0] wgt_wr, wgt_rd;

    logic act_push, act_ok, act_store, act_drop, act_pop, act_ne;
    logic wgt_push, wgt_ok, wgt_store, wgt_drop, wgt_pop, wgt_ne;
    logic [8:0] drop_sum;
    pkt_t act_head, wgt_head;

    always_comb begin
        act_in_ready = rst & (act_count < CW'(DEPTH));
        wgt_in_ready = rst & (wgt_count < CW'(DEPTH));
        act_push  = act_in_valid & act_in_ready;
        wgt_push  = wgt_in_valid & wgt_in_ready;
        act_ok    = 32'(act_in_tag) < COL_LIM;
        wgt_ok    = 32'(wgt_in_tag) < ROW_LIM;
        act_store = act_push & act_ok;
        wgt_store = wgt_push & wgt_ok;
        act_drop  = act_push & ~act_ok;
        wgt_drop  = wgt_push & ~wgt_ok;
        act_ne    = act_count != '0;
        wgt_ne    = wgt_count != '0;
        // Paired issue holds both heads until the partner bus has data too
        act_pop   = ~stall & (pair_mode ? (act_ne & wgt_ne) : act_ne);
        wgt_pop   = ~stall & (pair_mode ? (act_ne & wgt_ne) : wgt_ne);
        act_head  = act_mem[act_rd];
        wgt_head  = wgt_mem[wgt_rd];
        drop_sum  = {1'b0, drop_count} + {8'b0, act_drop} + {8'b0, wgt_drop};
    end

    // Storage needs no reset: pointers and counts decide what is live
    always_ff @(posedge clk) begin
        if (act_store) act_mem[act_wr] <= {act_in_data, act_in_tag};
        if (wgt_store) wgt_mem[wgt_wr] <= {wgt_in_data, wgt_in_tag};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_wr    <= '0;
            act_rd    <= '0;
            act_count <= '0;
            wgt_wr    <= '0;
            wgt_rd    <= '0;
            wgt_count <= '0;
        end else begin
            if (act_store) act_wr <= act_wr + AW'(1);
            if (act_pop)   act_rd <= act_rd + AW'(1);
            if (wgt_store) wgt_wr <= wgt_wr + AW'(1);
            if (wgt_pop)   wgt_rd <= wgt_rd + AW'(1);
            act_count <= act_count + CW'(act_store) - CW'(act_pop);
            wgt_count <= wgt_count + CW'(wgt_store) - CW'(wgt_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            image_val_in  <= '0;
            tag_col       <= '0;
            valid_x       <= 1'b0;
            weight_val_in <= '0;
            tag_row       <= '0;
            valid_y       <= 1'b0;
        end else begin
            valid_x       <= act_pop;
            image_val_in  <= act_pop ? act_head.data : '0;
            tag_col       <= act_pop ? act_head.tag : '0;
            valid_y       <= wgt_pop;
            weight_val_in <= wgt_pop ? wgt_head.data : '0;
            tag_row       <= wgt_pop ? wgt_head.tag : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_err    <= 1'b0;
            drop_count <= '0;
        end else begin
            tag_err    <= tag_err | act_drop | wgt_drop;
            drop_count <= drop_sum[8] ? 8'hff : drop_sum[7:0];
        end
    end

endmodule

// File: tb/tb_pe_grid_feeder.sv
// Randomised scoreboard bench for pe_grid_feeder against a queue-based model.
module tb_pe_grid_feeder;

    localparam int DATA_W = 16;
    localparam int TAG_W  = 4;
    localparam int DEPTH  = 8;
    localparam int COLS   = 14;
    localparam int ROWS   = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [DATA_W-1:0] act_in_data = '0, wgt_in_data = '0;
    logic [TAG_W-1:0]  act_in_tag = '0, wgt_in_tag = '0;
    logic act_in_valid = 1'b0, wgt_in_valid = 1'b0;
    logic act_in_ready, wgt_in_ready;
    logic pair_mode = 1'b0, stall = 1'b0;
    logic [DATA_W-1:0] image_val_in, weight_val_in;
    logic [TAG_W-1:0]  tag_col, tag_row;
    logic valid_x, valid_y;
    logic [$clog2(DEPTH):0] act_count, wgt_count;
    logic tag_err;
    logic [7:0] drop_count;

    pe_grid_feeder #(
        .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH),
        .COLS(COLS), .ROWS(ROWS)
    ) dut (
        .clk(clk), .rst(rst),
        .act_in_data(act_in_data), .act_in_tag(act_in_tag),
        .act_in_valid(act_in_valid), .act_in_ready(act_in_ready),
        .wgt_in_data(wgt_in_data), .wgt_in_tag(wgt_in_tag),
        .wgt_in_valid(wgt_in_valid), .wgt_in_ready(wgt_in_ready),
        .pair_mode(pair_mode), .stall(stall),
        .image_val_in(image_val_in), .tag_col(tag_col), .valid_x(valid_x),
        .weight_val_in(weight_val_in), .tag_row(tag_row), .valid_y(valid_y),
        .act_count(act_count), .wgt_count(wgt_count),
        .tag_err(tag_err), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [TAG_W-1:0]  t;
    } pkt_t;

    pkt_t aq[$], wq[$];
    pkt_t sb_act[$], sb_wgt[$];
    pkt_t p;
    bit exp_vx, exp_vy, m_err;
    int m_drops;
    bit ra, rw, pa, pw;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference model: FIFOs as queues, issued packets go to the scoreboard
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            aq.delete(); wq.delete();
            sb_act.delete(); sb_wgt.delete();
            exp_vx = 0; exp_vy = 0; m_err = 0; m_drops = 0;
        end else begin
            ra = aq.size() < DEPTH;
            rw = wq.size() < DEPTH;
            if (pair_mode) begin
                pa = !stall && aq.size() > 0 && wq.size() > 0;
                pw = pa;
            end else begin
                pa = !stall && aq.size() > 0;
                pw = !stall && wq.size() > 0;
            end
            exp_vx = pa;
            exp_vy = pw;
            if (pa) sb_act.push_back(aq.pop_front());
            if (pw) sb_wgt.push_back(wq.pop_front());
            if (act_in_valid && ra) begin
                if (act_in_tag < COLS) aq.push_back('{act_in_data, act_in_tag});
                else begin m_err = 1; if (m_drops < 255) m_drops++; end
            end
            if (wgt_in_valid && rw) begin
                if (wgt_in_tag < ROWS) wq.push_back('{wgt_in_data, wgt_in_tag});
                else begin m_err = 1; if (m_drops < 255) m_drops++; end
            end
        end
    end

    // Monitor: consumes scoreboard entries whenever the DUT issues
    always @(negedge clk) begin
        chk("valid_x", valid_x, exp_vx);
        chk("valid_y", valid_y, exp_vy);
        if (valid_x === 1'b1) begin
            if (sb_act.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL act_unexpected: issued %0d/%0d, none expected",
                         image_val_in, tag_col);
            end else begin
                p = sb_act.pop_front();
                chk("act_data", image_val_in, p.d);
                chk("act_tag", tag_col, p.t);
            end
        end else begin
            chk("act_idle_data", image_val_in, 0);
            chk("act_idle_tag", tag_col, 0);
        end
        if (valid_y === 1'b1) begin
            if (sb_wgt.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL wgt_unexpected: issued %0d/%0d, none expected",
                         weight_val_in, tag_row);
            end else begin
                p = sb_wgt.pop_front();
                chk("wgt_data", weight_val_in, p.d);
                chk("wgt_tag", tag_row, p.t);
            end
        end else begin
            chk("wgt_idle_data", weight_val_in, 0);
            chk("wgt_idle_tag", tag_row, 0);
        end
        chk("act_count", act_count, aq.size());
        chk("wgt_count", wgt_count, wq.size());
        chk("act_ready", act_in_ready, rst && aq.size() < DEPTH);
        chk("wgt_ready", wgt_in_ready, rst && wq.size() < DEPTH);
        chk("tag_err", tag_err, m_err);
        chk("drop_count", drop_count, m_drops);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        act_in_valid = 0;
        wgt_in_valid = 0;
    endtask

    initial begin
        bit got;
        step();
        chk("rst_act_ready", act_in_ready, 0);
        chk("rst_valid_x", valid_x, 0);
        step();
        rst = 1;

        // Independent issue of one act/wgt pair
        act_in_data = 4; act_in_tag = 5; act_in_valid = 1;
        wgt_in_data = 10; wgt_in_tag = 3; wgt_in_valid = 1;
        step();
        idle_inputs();
        chk("t1_not_yet", valid_x, 0);
        step();
        chk("t1_vx", valid_x, 1);
        chk("t1_vy", valid_y, 1);
        chk("t1_img", image_val_in, 4);
        chk("t1_wgt", weight_val_in, 10);
        repeat (2) step();

        // Paired issue waits for the partner
        pair_mode = 1;
        act_in_data = 7; act_in_tag = 2; act_in_valid = 1;
        step();
        idle_inputs();
        repeat (5) step();
        wgt_in_data = 3; wgt_in_tag = 1; wgt_in_valid = 1;
        step();
        idle_inputs();
        repeat (3) step();
        pair_mode = 0;

        // Fill under stall, then release
        stall = 1;
        for (int i = 0; i < 12; i++) begin
            act_in_data = DATA_W'(100 + (i < 8 ? i : 8));
            act_in_tag = TAG_W'(i % COLS);
            act_in_valid = 1;
            step();
        end
        chk("fill_count", act_count, 8);
        chk("fill_ready", act_in_ready, 0);
        stall = 0;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            if (act_in_ready) begin got = 1; break; end
            step();
        end
        if (!got) begin
            vectors++; miscompares++;
            $display("FAIL fill_timeout: ready %0d required 1", act_in_ready);
        end
        step();
        idle_inputs();
        repeat (12) step();

        // Out-of-range tags
        act_in_tag = 14; act_in_valid = 1;
        wgt_in_tag = 12; wgt_in_valid = 1;
        step();
        idle_inputs();
        repeat (2) step();
        chk("drop2", drop_count, 2);
        chk("err1", tag_err, 1);
        for (int i = 0; i < 300; i++) begin
            act_in_valid = 1; act_in_tag = TAG_W'($urandom_range(14, 15));
            wgt_in_valid = 1; wgt_in_tag = TAG_W'($urandom_range(12, 15));
            act_in_data = DATA_W'($urandom); wgt_in_data = DATA_W'($urandom);
            step();
        end
        idle_inputs();
        step();
        chk("drop_sat", drop_count, 255);

        // Steady stream holding count at 3 across pointer wrap
        stall = 1;
        for (int i = 0; i < 28; i++) begin
            act_in_valid = 1; act_in_data = DATA_W'(500 + i);
            act_in_tag = TAG_W'($urandom_range(0, COLS - 1));
            wgt_in_valid = 1; wgt_in_data = DATA_W'(900 + i);
            wgt_in_tag = TAG_W'($urandom_range(0, ROWS - 1));
            step();
            if (i == 2) stall = 0;
            if (i >= 3) chk("steady_count", act_count, 3);
        end
        idle_inputs();
        repeat (6) step();

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            act_in_valid = ($urandom_range(0, 9) < 6);
            wgt_in_valid = ($urandom_range(0, 9) < 6);
            act_in_data = DATA_W'($urandom); wgt_in_data = DATA_W'($urandom);
            act_in_tag = TAG_W'($urandom_range(0, 14));
            wgt_in_tag = TAG_W'($urandom_range(0, 12));
            stall = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 19) == 0) pair_mode = ~pair_mode;
            step();
        end
        idle_inputs();
        stall = 0; pair_mode = 0;
        repeat (12) step();

        // Reset with data buffered and a packet on the bus
        stall = 1;
        for (int i = 0; i < 5; i++) begin
            act_in_valid = 1; act_in_data = DATA_W'(700 + i); act_in_tag = 1;
            wgt_in_valid = 1; wgt_in_data = DATA_W'(800 + i); wgt_in_tag = 1;
            step();
        end
        idle_inputs();
        stall = 0;
        step();
        chk("pre_rst_vx", valid_x, 1);
        rst = 0;
        #1;
        chk("async_vx", valid_x, 0);
        chk("async_vy", valid_y, 0);
        chk("async_img", image_val_in, 0);
        chk("async_cnt", act_count, 0);
        chk("async_rdy", wgt_in_ready, 0);
        repeat (2) step();
        rst = 1;
        for (int i = 0; i < 40; i++) begin
            act_in_valid = ($urandom_range(0, 3) == 0);
            wgt_in_valid = ($urandom_range(0, 3) == 0);
            act_in_data = DATA_W'($urandom); wgt_in_data = DATA_W'($urandom);
            act_in_tag = TAG_W'($urandom_range(0, COLS - 1));
            wgt_in_tag = TAG_W'($urandom_range(0, ROWS - 1));
            step();
        end
        idle_inputs();
        repeat (12) step();
        chk("sb_act_drained", sb_act.size(), 0);
        chk("sb_wgt_drained", sb_wgt.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
